bp_be_fp_result_collector: RTL and testbench
============================================

// Module: bp_be_fp_result_collector
// PURPOSE
//  Receives completed results and exception flags from the hardfloat FPU, buffers them in a
//  2-entry FIFO, NaN-boxes single-precision FP-destination results, and returns them to the
//  writeback stage over a valid/ready handshake. Exception flags are OR-accumulated into a
//  sticky fflags register on writeback handshake. Flags of flushed results are discarded.
//  The fflags register has a CSR read/write port.
// PARAMETERS
//  dword_width_p   64  result data width
//  word_width_p    32  single-precision payload width (low bits of data)
//  reg_addr_width_p 5  destination register address width
// PORTS
//  clk_i            in   1   clock
//  reset_i          in   1   synchronous, active-high reset
//  fpu_v_i          in   1   FPU result valid
//  fpu_ready_o      out  1   collector can accept a result (not full)
//  fpu_data_i       in   64  FPU result (o)
//  fpu_eflags_i     in   5   bsg_fp_eflags_s {nv,dz,of,uf,nx}
//  fpu_opr_i        in   1   bsg_fp_pr_e output precision (e_pr_single / e_pr_double)
//  fpu_fp_dest_i    in   1   1 = FP regfile destination, 0 = integer (direct results)
//  fpu_rd_addr_i    in   5   destination register
//  flush_i          in   1   discard all buffered and incoming results
//  wb_v_o           out  1   writeback entry valid
//  wb_ready_i       in   1   writeback stage accepts entry
//  wb_data_o        out  64  writeback data (boxed as required)
//  wb_fp_dest_o     out  1   destination file select
//  wb_rd_addr_o     out  5   destination register
//  fflags_w_v_i     in   1   CSR write of fflags
//  fflags_w_data_i  in   5   CSR write value
//  fflags_o         out  5   current sticky fflags
// BEHAVIOUR
//  - Reset: FIFO empty, wb_v_o=0, fpu_ready_o=1, fflags_o=0, all wb_* data outputs 0.
//  - Enqueue when fpu_v_i & fpu_ready_o & ~flush_i. Dequeue when wb_v_o & wb_ready_i & ~flush_i.
//  - FSM on occupancy: EMPTY -> ONE (enq); ONE -> TWO (enq, no deq); ONE -> EMPTY (deq, no enq);
//    ONE stays ONE on simultaneous enq+deq; TWO -> ONE (deq). No enq accepted in TWO.
//  - fpu_ready_o = (state != TWO); registered state only, no combinational path from wb_ready_i.
//  - wb_v_o = (state != EMPTY); wb_* show the oldest entry, registered (no input bypass).
//  - Latency: result accepted in cycle N appears on wb_v_o in cycle N+1 at earliest.
//  - FIFO order strictly preserved; 1-bit read/write pointers wrap 1->0.
//  - Boxing at enqueue: if fpu_fp_dest_i & fpu_opr_i==e_pr_single, stored data =
//    {32'hFFFF_FFFF, fpu_data_i[31:0]}; otherwise fpu_data_i stored unchanged.
//  - fflags next value:
//      fflags_w_v_i : fflags_w_data_i | (deq ? head.eflags : 0)
//      else         : fflags_o        | (deq ? head.eflags : 0)
//    Flags of enqueued-but-flushed entries never reach fflags_o.
//  - flush_i: next cycle state=EMPTY, both pointers 0; same-cycle enq and deq are suppressed;
//    fflags_o unaffected by flushed entries but CSR write in same cycle still applies.
//  - reset_i dominates flush_i and all handshakes; reset mid-stream drops entries, clears fflags.
//  - Data of non-head entries is don't-care on outputs; wb_* hold value while wb_v_o & ~wb_ready_i.
// TESTING
//  1 Single result 0x3F80_0000, opr=single, fp_dest=1, rd=3, wb_ready=1 -> next cycle wb_v_o=1,
//    wb_data_o=0xFFFF_FFFF_3F80_0000, rd=3; fpu_ready_o stays 1.
//  2 Int-dest single (feq=1) data 0x1 -> wb_data_o=0x0000_0000_0000_0001 (no boxing).
//  3 wb_ready=0, enqueue 3 back-to-back -> 2 accepted, fpu_ready_o=0 after 2nd; release
//    wb_ready -> entries emerge in order, third accepted after first dequeue.
//  4 Entries with eflags nx(0x01) then of|nx(0x05) retire -> fflags_o 0x01 then 0x05;
//    CSR write 0x00 same cycle as nv(0x10) retire -> fflags_o=0x10.
//  5 Two entries with eflags dz buffered, flush_i pulsed with concurrent fpu_v_i -> next cycle
//    wb_v_o=0, fpu_ready_o=1, fflags_o unchanged (0).
//  6 reset_i asserted while FIFO full and fflags=0x1F -> next cycle wb_v_o=0, fflags_o=0.

Source files
------------

// File: rtl/bp_be_fp_result_collector.sv
// FP result collector: buffers FPU results in a 2-entry FIFO, NaN-boxes single-precision
// FP-destination results on entry, and hands them to writeback over valid/ready. Exception
// flags of retired results accumulate into a sticky fflags register with a CSR write port.
module bp_be_fp_result_collector #(
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned word_width_p     = 32,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        fpu_v_i,
  output logic                        fpu_ready_o,
  input  logic [dword_width_p-1:0]    fpu_data_i,
  input  logic [4:0]                  fpu_eflags_i,
  input  logic                        fpu_opr_i,
  input  logic                        fpu_fp_dest_i,
  input  logic [reg_addr_width_p-1:0] fpu_rd_addr_i,

  input  logic                        flush_i,

  output logic                        wb_v_o,
  input  logic                        wb_ready_i,
  output logic [dword_width_p-1:0]    wb_data_o,
  output logic                        wb_fp_dest_o,
  output logic [reg_addr_width_p-1:0] wb_rd_addr_o,

  input  logic                        fflags_w_v_i,
  input  logic [4:0]                  fflags_w_data_i,
  output logic [4:0]                  fflags_o
);

  // Output precision encoding of the FPU.
  localparam logic PrSingle = 1'b1;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                      state_q;
  logic                        fpu_ready_q;
  logic                        wb_v_q;
  logic                        wptr_q;
  logic                        rptr_q;
  logic [dword_width_p-1:0]    data_q    [2];
  logic [4:0]                  eflags_q  [2];
  logic [1:0]                  fp_dest_q;
  logic [reg_addr_width_p-1:0] rd_addr_q [2];
  logic [4:0]                  fflags_q;
  logic [4:0]                  fflags_d;

  logic                        enq;
  logic                        deq;
  logic [dword_width_p-1:0]    enq_data;

  // Handshakes use only registered ready/valid, so there is no wb_ready_i -> fpu_ready_o path.
  always_comb begin
    enq = fpu_v_i & fpu_ready_q & ~flush_i;
    deq = wb_v_q & wb_ready_i & ~flush_i;
  end

  // NaN-box single-precision results headed for the FP regfile.
  always_comb begin
    enq_data = fpu_data_i;
    if (fpu_fp_dest_i && (fpu_opr_i == PrSingle)) begin
      enq_data = {{(dword_width_p - word_width_p){1'b1}}, fpu_data_i[word_width_p-1:0]};
    end
  end

  // Occupancy FSM with registered ready/valid outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      state_q     <= StEmpty;
      fpu_ready_q <= 1'b1;
      wb_v_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (enq) begin
            state_q <= StOne;
            wb_v_q  <= 1'b1;
          end
        end
        StOne: begin
          if (enq && !deq) begin
            state_q     <= StTwo;
            fpu_ready_q <= 1'b0;
          end else if (deq && !enq) begin
            state_q <= StEmpty;
            wb_v_q  <= 1'b0;
          end
        end
        StTwo: begin
          if (deq) begin
            state_q     <= StOne;
            fpu_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          fpu_ready_q <= 1'b1;
          wb_v_q      <= 1'b0;
        end
      endcase
    end
  end

  // Read/write pointers; a flush rewinds both so the next entry lands in slot 0.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
    end
  end

  // Entry storage; cleared on reset so the idle writeback outputs read as zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]    <= '0;
        eflags_q[i]  <= '0;
        rd_addr_q[i] <= '0;
      end
      fp_dest_q <= '0;
    end else if (enq) begin
      data_q[wptr_q]    <= enq_data;
      eflags_q[wptr_q]  <= fpu_eflags_i;
      fp_dest_q[wptr_q] <= fpu_fp_dest_i;
      rd_addr_q[wptr_q] <= fpu_rd_addr_i;
    end
  end

  // Sticky flags: CSR write replaces the base, the retiring entry's flags are ORed on top.
  always_comb begin
    fflags_d = fflags_w_v_i ? fflags_w_data_i : fflags_q;
    if (deq) fflags_d = fflags_d | eflags_q[rptr_q];
  end

  // Sticky fflags register.
  always_ff @(posedge clk_i) begin
    if (reset_i) fflags_q <= '0;
    else         fflags_q <= fflags_d;
  end

  assign fpu_ready_o  = fpu_ready_q;
  assign wb_v_o       = wb_v_q;
  assign wb_data_o    = data_q[rptr_q];
  assign wb_fp_dest_o = fp_dest_q[rptr_q];
  assign wb_rd_addr_o = rd_addr_q[rptr_q];
  assign fflags_o     = fflags_q;

endmodule

// File: tb/tb_bp_be_fp_result_collector.sv
// Self-checking bench for bp_be_fp_result_collector: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_bp_be_fp_result_collector;

  logic        clk;
  logic        reset;
  logic        fpu_v;
  logic        fpu_ready;
  logic [63:0] fpu_data;
  logic [4:0]  fpu_eflags;
  logic        fpu_opr;
  logic        fpu_fp_dest;
  logic [4:0]  fpu_rd;
  logic        flush;
  logic        wb_v;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic        wb_fp_dest;
  logic [4:0]  wb_rd;
  logic        fw_v;
  logic [4:0]  fw_data;
  logic [4:0]  fflags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  ef;
    logic        fpd;
    logic [4:0]  rd;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_fflags;

  bp_be_fp_result_collector dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .fpu_v_i         (fpu_v),
    .fpu_ready_o     (fpu_ready),
    .fpu_data_i      (fpu_data),
    .fpu_eflags_i    (fpu_eflags),
    .fpu_opr_i       (fpu_opr),
    .fpu_fp_dest_i   (fpu_fp_dest),
    .fpu_rd_addr_i   (fpu_rd),
    .flush_i         (flush),
    .wb_v_o          (wb_v),
    .wb_ready_i      (wb_ready),
    .wb_data_o       (wb_data),
    .wb_fp_dest_o    (wb_fp_dest),
    .wb_rd_addr_o    (wb_rd),
    .fflags_w_v_i    (fw_v),
    .fflags_w_data_i (fw_data),
    .fflags_o        (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 0; fpu_v = 0; fpu_data = '0; fpu_eflags = '0; fpu_opr = 0; fpu_fp_dest = 0;
    fpu_rd = '0; flush = 0; wb_ready = 1; fw_v = 0; fw_data = '0;
  endtask

  task automatic put(input logic [63:0] d, input logic [4:0] ef, input logic opr,
                     input logic fpd, input logic [4:0] rd);
    fpu_v = 1; fpu_data = d; fpu_eflags = ef; fpu_opr = opr; fpu_fp_dest = fpd; fpu_rd = rd;
  endtask

  // Advance one clock and update the reference model from the inputs held across the edge.
  task automatic tick();
    logic       e, d;
    ent_t       ent;
    logic [4:0] nf;
    e = fpu_v & (mq.size() < 2) & ~flush & ~reset;
    d = (mq.size() > 0) & wb_ready & ~flush & ~reset;
    ent.data = (fpu_fp_dest && fpu_opr) ? {32'hFFFF_FFFF, fpu_data[31:0]} : fpu_data;
    ent.ef = fpu_eflags; ent.fpd = fpu_fp_dest; ent.rd = fpu_rd;
    nf = fw_v ? fw_data : m_fflags;
    if (d) nf = nf | mq[0].ef;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_fflags = '0;
    end else begin
      m_fflags = nf;
      if (d) void'(mq.pop_front());
      if (e) mq.push_back(ent);
      if (flush) mq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_checks++; if (wb_v !== 1'b0) begin n_fail++; $display("FAIL reset_wb_v got %b want 0", wb_v); end
    n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", fpu_ready); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL reset_fflags got %h want 00", fflags); end
    n_checks++;
    if ({wb_data, wb_fp_dest, wb_rd} !== 70'd0) begin
      n_fail++; $display("FAIL reset_wb_data got %h/%b/%0d want 0", wb_data, wb_fp_dest, wb_rd);
    end
  endtask

  task automatic test_boxing();
    idle_inputs();
    put(64'h0000_0000_3F80_0000, 5'h00, 1'b1, 1'b1, 5'd3);
    tick();
    fpu_v = 0;
    n_checks++; if (wb_v !== 1'b1) begin n_fail++; $display("FAIL box_wb_v got %b want 1", wb_v); end
    n_checks++;
    if (wb_data !== 64'hFFFF_FFFF_3F80_0000) begin
      n_fail++; $display("FAIL box_data got %h want ffffffff3f800000", wb_data);
    end
    n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL box_rd got %0d want 3", wb_rd); end
    n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL box_ready got %b want 1", fpu_ready); end
    tick();
    n_checks++; if (wb_v !== 1'b0) begin n_fail++; $display("FAIL box_drain got %b want 0", wb_v); end
    // Integer destination: single result left unboxed.
    put(64'h1, 5'h00, 1'b1, 1'b0, 5'd7);
    tick();
    fpu_v = 0;
    n_checks++;
    if (wb_data !== 64'h1 || wb_fp_dest !== 1'b0) begin
      n_fail++; $display("FAIL int_nobox got %h/%b want 1/0", wb_data, wb_fp_dest);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    wb_ready = 0;
    put(64'hA, 5'h0, 1'b0, 1'b0, 5'd1); tick();
    put(64'hB, 5'h0, 1'b0, 1'b0, 5'd2); tick();
    n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b want 0", fpu_ready); end
    put(64'hC, 5'h0, 1'b0, 1'b0, 5'd3); tick();
    n_checks++;
    if (wb_v !== 1'b1 || wb_data !== 64'hA || fpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_hold got v=%b d=%h r=%b want 1/a/0", wb_v, wb_data, fpu_ready);
    end
    wb_ready = 1; tick();  // A leaves, C refused (full)
    n_checks++;
    if (wb_data !== 64'hB || wb_rd !== 5'd2 || fpu_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got d=%h rd=%0d r=%b want b/2/1", wb_data, wb_rd, fpu_ready);
    end
    tick();  // B leaves, C accepted
    fpu_v = 0;
    n_checks++;
    if (wb_v !== 1'b1 || wb_data !== 64'hC || wb_rd !== 5'd3) begin
      n_fail++; $display("FAIL b2b_third got v=%b d=%h rd=%0d want 1/c/3", wb_v, wb_data, wb_rd);
    end
    tick();
    n_checks++; if (wb_v !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", wb_v); end
  endtask

  task automatic test_fflags();
    idle_inputs();
    fw_v = 1; fw_data = 5'h00; tick(); fw_v = 0;
    put(64'h1, 5'h01, 1'b0, 1'b1, 5'd1); tick();
    put(64'h2, 5'h05, 1'b0, 1'b1, 5'd2); tick();
    fpu_v = 0;
    n_checks++; if (fflags !== 5'h01) begin n_fail++; $display("FAIL ff_nx got %h want 01", fflags); end
    tick();
    n_checks++; if (fflags !== 5'h05) begin n_fail++; $display("FAIL ff_ofnx got %h want 05", fflags); end
    put(64'h3, 5'h10, 1'b0, 1'b1, 5'd3); tick();
    fpu_v = 0; fw_v = 1; fw_data = 5'h00; tick(); fw_v = 0;
    n_checks++; if (fflags !== 5'h10) begin n_fail++; $display("FAIL ff_csr_nv got %h want 10", fflags); end
  endtask

  task automatic test_flush();
    idle_inputs();
    fw_v = 1; fw_data = 5'h00; tick(); fw_v = 0;
    wb_ready = 0;
    put(64'h11, 5'h08, 1'b0, 1'b1, 5'd4); tick();
    put(64'h22, 5'h08, 1'b0, 1'b1, 5'd5); tick();
    flush = 1; wb_ready = 1; tick();
    flush = 0; fpu_v = 0;
    n_checks++; if (wb_v !== 1'b0) begin n_fail++; $display("FAIL flush_wb_v got %b want 0", wb_v); end
    n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", fpu_ready); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL flush_fflags got %h want 00", fflags); end
    tick();
    n_checks++; if (fflags !== 5'h00 || wb_v !== 1'b0) begin
      n_fail++; $display("FAIL flush_after got ff=%h v=%b want 00/0", fflags, wb_v);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    wb_ready = 0; fw_v = 1; fw_data = 5'h1F;
    put(64'h33, 5'h01, 1'b0, 1'b1, 5'd6); tick();
    fw_v = 0;
    put(64'h44, 5'h01, 1'b0, 1'b1, 5'd7); tick();
    fpu_v = 0;
    n_checks++; if (fpu_ready !== 1'b0 || fflags !== 5'h1F) begin
      n_fail++; $display("FAIL rst_pre got r=%b ff=%h want 0/1f", fpu_ready, fflags);
    end
    reset = 1; tick(); reset = 0;
    n_checks++; if (wb_v !== 1'b0 || fflags !== 5'h00 || fpu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got v=%b ff=%h r=%b want 0/00/1", wb_v, fflags, fpu_ready);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      fpu_v       = ($urandom_range(0, 99) < 60);
      fpu_data    = {$urandom, $urandom};
      fpu_eflags  = 5'($urandom);
      fpu_opr     = 1'($urandom);
      fpu_fp_dest = 1'($urandom);
      fpu_rd      = 5'($urandom);
      wb_ready    = ($urandom_range(0, 99) < 55);
      flush       = ($urandom_range(0, 99) < 5);
      reset       = ($urandom_range(0, 99) < 2);
      fw_v        = ($urandom_range(0, 99) < 8);
      fw_data     = 5'($urandom);
      tick();
      n_checks++;
      if (wb_v !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL rnd_wb_v cyc %0d got %b want %b", i, wb_v, mq.size() > 0);
      end
      n_checks++;
      if (fpu_ready !== (mq.size() < 2)) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, fpu_ready, mq.size() < 2);
      end
      n_checks++;
      if (fflags !== m_fflags) begin
        n_fail++; $display("FAIL rnd_fflags cyc %0d got %h want %h", i, fflags, m_fflags);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (wb_data !== mq[0].data || wb_fp_dest !== mq[0].fpd || wb_rd !== mq[0].rd) begin
          n_fail++;
          $display("FAIL rnd_head cyc %0d got %h/%b/%0d want %h/%b/%0d", i, wb_data, wb_fp_dest,
                   wb_rd, mq[0].data, mq[0].fpd, mq[0].rd);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_fflags = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_boxing();
    test_back_to_back();
    test_fflags();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
